// File: rtl/chip8_keypad_scanner.sv
// -----------------------------------------------------------------------------
// chip8_keypad_scanner
//
// Scans a 4x4 hex keypad matrix one column at a time, debounces whole-matrix
// snapshots, and presents the key state used by the CHIP-8 core
// (Ex9E / ExA1 / Fx0A).
//
// Ports:
//   clk              single clock for all logic
//   rst              asynchronous, active-low reset
//   row_sense[3:0]   keypad rows, active-low, asynchronous to clk
//   col_drive[3:0]   keypad columns, active-low, one column low while scanning
//   input_keys[15:0] debounced key state, bit k = hex key k held
//   newest_key_down  index 0-15 of the most recently pressed, still-held key;
//                    16 means no such key
//   key_event        one-cycle pulse when newest_key_down takes a value 0-15
//   scan_state[1:0]  current scan FSM state (0 DRIVE, 1 SAMPLE, 2 COMMIT)
//
// Output timing: key_event is a single-cycle strobe with no back-pressure.
// It is high in exactly the cycle in which input_keys and newest_key_down
// first show the new values; the consumer must sample it in that cycle.
// -----------------------------------------------------------------------------
module chip8_keypad_scanner #(
    parameter int SETTLE_CYCLES  = 3,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_sense,
    output logic [3:0]  col_drive,
    output logic [15:0] input_keys,
    output logic [4:0]  newest_key_down,
    output logic        key_event,
    output logic [1:0]  scan_state
);

    // Settle counter runs 0 .. SETTLE_CYCLES-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Stable-scan counter runs 0 .. DEBOUNCE_SCANS (saturating).
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_SCANS);
    localparam logic [4:0]    NO_KEY      = 5'd16;

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Key map: row r / column c -> hex key index.
    //   r0: 1 2 3 C
    //   r1: 4 5 6 D
    //   r2: 7 8 9 E
    //   r3: A 0 B F
    // -------------------------------------------------------------------------
    function automatic logic [3:0] key_index(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hC;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hD;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hE;
            4'b11_00: k = 4'hA;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hB;
            default:  k = 4'hF;
        endcase
        return k;
    endfunction

    // Overwrite the four key bits belonging to one column of the raw scan.
    function automatic logic [15:0] merge_column(input logic [15:0] scan,
                                                 input logic [1:0]  col,
                                                 input logic [3:0]  rows);
        logic [15:0] res;
        res = scan;
        for (int r = 0; r < 4; r++) begin
            res[key_index(2'(r), col)] = rows[r];
        end
        return res;
    endfunction

    // Lowest set bit index; caller guarantees v != 0.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [1:0]     column_q, column_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [DW-1:0]  stable_q, stable_d;
    logic [15:0]    prev_scan_q, prev_scan_d;
    logic [15:0]    raw_scan_q, raw_scan_d;
    logic [3:0]     sync1_q, sync2_q;
    logic [15:0]    keys_d;
    logic [4:0]     newest_d;
    logic           event_d;

    logic [3:0]     drive;
    logic [3:0]     rows_active;
    logic [15:0]    rising;

    // Rows are pulled up; a pressed key in the driven column pulls its row low.
    assign rows_active = ~sync2_q;
    assign scan_state  = state_q;

    // Columns float high (all ones) during reset so nothing is driven while
    // the board comes up; the gate is on the reset pin itself so it takes
    // effect without waiting for a clock.
    assign col_drive = rst ? drive : 4'b1111;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        column_d    = column_q;
        settle_d    = settle_q;
        stable_d    = stable_q;
        prev_scan_d = prev_scan_q;
        raw_scan_d  = raw_scan_q;
        keys_d      = input_keys;
        newest_d    = newest_key_down;
        event_d     = 1'b0;
        drive       = 4'b1111;
        rising      = '0;

        case (state_q)
            ST_DRIVE: begin
                drive = ~(4'b0001 << column_q);
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                // Column stays driven while the synchronized rows are latched.
                drive      = ~(4'b0001 << column_q);
                raw_scan_d = merge_column(raw_scan_q, column_q, rows_active);
                if (column_q != 2'd3) begin
                    column_d = column_q + 2'd1;
                    state_d  = ST_DRIVE;
                end else begin
                    state_d = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                if (raw_scan_q == prev_scan_q) begin
                    if (stable_q >= STABLE_MAX) begin
                        stable_d = STABLE_MAX;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    stable_d = DW'(1);
                end
                prev_scan_d = raw_scan_q;

                if (stable_d >= STABLE_MAX) begin
                    keys_d = raw_scan_q;
                    rising = raw_scan_q & ~input_keys;
                    // A newly pressed key always takes over the report, even
                    // if the previously reported key was released in the
                    // same scan.
                    if (rising != 16'd0) begin
                        newest_d = {1'b0, lowest_set(rising)};
                        event_d  = 1'b1;
                    end else if (newest_key_down != NO_KEY &&
                                 !raw_scan_q[newest_key_down[3:0]]) begin
                        newest_d = NO_KEY;
                    end
                end

                column_d = 2'd0;
                state_d  = ST_DRIVE;
            end

            default: begin
                column_d = 2'd0;
                settle_d = '0;
                state_d  = ST_DRIVE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= row_sense;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_DRIVE;
            column_q        <= '0;
            settle_q        <= '0;
            stable_q        <= '0;
            prev_scan_q     <= '0;
            raw_scan_q      <= '0;
            input_keys      <= '0;
            newest_key_down <= NO_KEY;
            key_event       <= 1'b0;
        end else begin
            state_q         <= state_d;
            column_q        <= column_d;
            settle_q        <= settle_d;
            stable_q        <= stable_d;
            prev_scan_q     <= prev_scan_d;
            raw_scan_q      <= raw_scan_d;
            input_keys      <= keys_d;
            newest_key_down <= newest_d;
            key_event       <= event_d;
        end
    end

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_chip8_keypad_scanner
//
// Instance a: default parameters (SETTLE_CYCLES 3, DEBOUNCE_SCANS 2).
// Instance b: SETTLE_CYCLES 7, DEBOUNCE_SCANS 1.
// A keypad model turns held keys plus col_drive into row_sense.
// -----------------------------------------------------------------------------
module tb_chip8_keypad_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- DUT a ----------------
    logic [15:0] pressed;
    logic [3:0]  row_sense, col_drive;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;
    logic        key_event;
    logic [1:0]  scan_state;

    chip8_keypad_scanner #(.SETTLE_CYCLES(3), .DEBOUNCE_SCANS(2)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .row_sense       (row_sense),
        .col_drive       (col_drive),
        .input_keys      (input_keys),
        .newest_key_down (newest_key_down),
        .key_event       (key_event),
        .scan_state      (scan_state)
    );

    // ---------------- DUT b ----------------
    logic [15:0] pressed_b;
    logic [3:0]  row_sense_b, col_drive_b;
    logic [15:0] input_keys_b;
    logic [4:0]  newest_key_down_b;
    logic        key_event_b;
    logic [1:0]  scan_state_b;

    chip8_keypad_scanner #(.SETTLE_CYCLES(7), .DEBOUNCE_SCANS(1)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .row_sense       (row_sense_b),
        .col_drive       (col_drive_b),
        .input_keys      (input_keys_b),
        .newest_key_down (newest_key_down_b),
        .key_event       (key_event_b),
        .scan_state      (scan_state_b)
    );

    // ---------------- keypad model ----------------
    function automatic int key_at(input int r, input int c);
        int k;
        case (r * 4 + c)
            0:  k = 1;   1:  k = 2;   2:  k = 3;   3:  k = 12;
            4:  k = 4;   5:  k = 5;   6:  k = 6;   7:  k = 13;
            8:  k = 7;   9:  k = 8;   10: k = 9;   11: k = 14;
            12: k = 10;  13: k = 0;   14: k = 11;  default: k = 15;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] keys);
        logic [3:0] rows;
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!cols[c] && keys[key_at(r, c)]) rows[r] = 1'b0;
            end
        end
        return rows;
    endfunction

    assign row_sense   = rows_for(col_drive, pressed);
    assign row_sense_b = rows_for(col_drive_b, pressed_b);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Per-scan expectation: {input_keys, newest_key_down, key_event}
    logic [21:0] exp_q[$];
    bit          sb_active = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the cycle after a COMMIT (col_drive all high) is where the DUT
    // presents a scan result. Elsewhere key_event must be low and
    // input_keys must not move.
    bit          post_commit = 1'b0;
    logic [15:0] last_keys   = '0;
    int          scan_no     = 0;
    logic [21:0] exp_e;

    always @(negedge clk) begin
        if (!rst) begin
            post_commit = 1'b0;
            last_keys   = input_keys;
        end else if (sb_active) begin
            if (post_commit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty scan %0d actual=result required=expectation", scan_no);
                end else begin
                    exp_e = exp_q.pop_front();
                    check($sformatf("scan_out[%0d]", scan_no),
                          {10'd0, input_keys, newest_key_down, key_event}, {10'd0, exp_e});
                end
                scan_no++;
            end else begin
                check("key_event_idle", {31'd0, key_event}, 32'd0);
                check("keys_hold", {16'd0, input_keys}, {16'd0, last_keys});
            end
            last_keys   = input_keys;
            post_commit = (col_drive == 4'b1111);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_commit(input bit use_b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((use_b ? col_drive_b : col_drive) !== 4'b1111) && n < 100);
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL commit_timeout dut_%s actual=none required=commit", use_b ? "b" : "a");
        end
    endtask

    // Hold `keys` for one full scan and queue the result expected after it.
    task automatic run_scan(input logic [15:0] keys, input logic [15:0] exp_keys,
                            input logic [4:0] exp_newest, input logic exp_ev);
        pressed = keys;
        exp_q.push_back({exp_keys, exp_newest, exp_ev});
        wait_commit(1'b0);
    endtask

    function automatic logic [3:0] col_pattern(input int i);
        logic [3:0] p;
        p = 4'b1111;
        if (i < 16) p[i / 4] = 1'b0;
        return p;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst       = 1'b0;
        pressed   = '0;
        pressed_b = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_col_drive", {28'd0, col_drive}, 32'hF);
        check("rst_keys", {16'd0, input_keys}, 32'h0);
        check("rst_newest", {27'd0, newest_key_down}, 32'd16);
        check("rst_event", {31'd0, key_event}, 32'd0);
        check("rst_col_drive_b", {28'd0, col_drive_b}, 32'hF);

        // First scan: column sequence and period.
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.push_back({16'h0000, 5'd16, 1'b0});
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("col_seq[%0d]", i), {28'd0, col_drive}, {28'd0, col_pattern(i)});
        end

        // Idle scans 2..5.
        for (int i = 0; i < 4; i++) run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);

        // Key 5 steady press, then release.
        run_scan(16'h0020, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h0020, 16'h0020, 5'd5,  1'b1);
        run_scan(16'h0020, 16'h0020, 5'd5,  1'b0);
        run_scan(16'h0000, 16'h0020, 5'd5,  1'b0);
        run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);

        // Bounce on key 5 every scan, then hold.
        for (int i = 0; i < 6; i++) begin
            run_scan((i % 2 == 0) ? 16'h0020 : 16'h0000, 16'h0000, 5'd16, 1'b0);
        end
        run_scan(16'h0020, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h0020, 16'h0020, 5'd5,  1'b1);
        run_scan(16'h0000, 16'h0020, 5'd5,  1'b0);
        run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);

        // Hold 0, add 9 + C, release 9.
        run_scan(16'h0001, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h0001, 16'h0001, 5'd0,  1'b1);
        run_scan(16'h1201, 16'h0001, 5'd0,  1'b0);
        run_scan(16'h1201, 16'h1201, 5'd9,  1'b1);
        run_scan(16'h1201, 16'h1201, 5'd9,  1'b0);
        run_scan(16'h1001, 16'h1201, 5'd9,  1'b0);
        run_scan(16'h1001, 16'h1001, 5'd16, 1'b0);
        run_scan(16'h1001, 16'h1001, 5'd16, 1'b0);
        // Press 3, then swap 3 for 2 in one scan: the new press wins.
        run_scan(16'h1009, 16'h1001, 5'd16, 1'b0);
        run_scan(16'h1009, 16'h1009, 5'd3,  1'b1);
        run_scan(16'h1005, 16'h1009, 5'd3,  1'b0);
        run_scan(16'h1005, 16'h1005, 5'd2,  1'b1);
        run_scan(16'h0000, 16'h1005, 5'd2,  1'b0);
        run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);

        // Key F held, reset asserted while column 2 is being driven.
        run_scan(16'h8000, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h8000, 16'h8000, 5'd15, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col_drive !== 4'b1011 && n < 100);
        check("reach_col2", {28'd0, col_drive}, 32'hB);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_col_drive", {28'd0, col_drive}, 32'hF);
        check("mid_rst_keys", {16'd0, input_keys}, 32'h0);
        check("mid_rst_newest", {27'd0, newest_key_down}, 32'd16);
        check("mid_rst_event", {31'd0, key_event}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("restart_col0", {28'd0, col_drive}, 32'hE);
        run_scan(16'h8000, 16'h0000, 5'd16, 1'b0);
        run_scan(16'h8000, 16'h8000, 5'd15, 1'b1);
        run_scan(16'h0000, 16'h8000, 5'd15, 1'b0);
        run_scan(16'h0000, 16'h0000, 5'd16, 1'b0);

        // Let the monitor consume the last result.
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        sb_active = 1'b0;

        // Instance b: 33-cycle scan, single-scan debounce.
        wait_commit(1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col_drive_b !== 4'b1111 && n < 100);
        check("b_period", n, 32'd33);
        pressed_b = 16'h0020;
        wait_commit(1'b1);
        check("b_keys_before_commit", {16'd0, input_keys_b}, 32'h0);
        @(negedge clk);
        check("b_keys_press", {16'd0, input_keys_b}, 32'h0020);
        check("b_newest_press", {27'd0, newest_key_down_b}, 32'd5);
        check("b_event_press", {31'd0, key_event_b}, 32'd1);
        pressed_b = 16'h0000;
        wait_commit(1'b1);
        @(negedge clk);
        check("b_keys_release", {16'd0, input_keys_b}, 32'h0);
        check("b_newest_release", {27'd0, newest_key_down_b}, 32'd16);
        check("b_event_release", {31'd0, key_event_b}, 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
